// File: rtl/spi_burst_engine_pkg.sv
// spi_burst_engine_pkg: burst FSM state encoding and chip-select helpers
package spi_burst_engine_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam logic [7:0] CS_IDLE = 8'hFF;
  function automatic logic [7:0] cs_decode(input logic [2:0] sel);
    return ~(8'b1 << sel);
  endfunction
endpackage

// File: rtl/spi_burst_engine_if.sv
// spi_burst_engine_if: command handshake between burst engine and serializer
interface spi_burst_engine_if;
  logic       start_o;
  logic       stop_o;
  logic       write_o;
  logic       read_o;
  logic [7:0] SPI_Write_Data_o;
  logic [7:0] SPI_Read_Data_i;
  logic       trnfer_cmplte_i;
  logic [7:0] SPI_CS_Reg_o;
  modport master (
    output start_o, stop_o, write_o, read_o, SPI_Write_Data_o, SPI_CS_Reg_o,
    input  SPI_Read_Data_i, trnfer_cmplte_i
  );
  modport slave (
    input  start_o, stop_o, write_o, read_o, SPI_Write_Data_o, SPI_CS_Reg_o,
    output SPI_Read_Data_i, trnfer_cmplte_i
  );
endinterface

// File: rtl/spi_burst_engine_byte_fifo.sv
// spi_byte_fifo: first-word-fall-through byte FIFO with level, full and empty
module spi_byte_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] level
);
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               wr_en, rd_en;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];
  // depth is a power of two, so the level MSB alone marks full
  assign full  = level[FIFO_AW];
  assign empty = level == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(wr_en);
      rd_ptr <= rd_ptr + FIFO_AW'(rd_en);
      level  <= level + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/spi_burst_engine.sv
// spi_burst_engine: TX/RX byte FIFOs sequencing multi-byte bursts into the serializer
module spi_burst_engine
  import spi_burst_engine_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                 CLK_i,
  input  logic                 RSTn_i,
  input  logic                 RST_SYNC_i,
  input  logic                 TX_Push_i,
  input  logic [7:0]           TX_Data_i,
  output logic                 TX_Full_o,
  output logic [FIFO_AW:0]     TX_Level_o,
  input  logic                 RX_Pop_i,
  output logic [7:0]           RX_Data_o,
  output logic                 RX_Empty_o,
  output logic [FIFO_AW:0]     RX_Level_o,
  input  logic                 Go_i,
  input  logic [2:0]           CS_Sel_i,
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic                 Overrun_o,
  input  logic                 Ovr_Clr_i,
  spi_burst_engine_if.master   spi
);
  state_t           state;
  logic [FIFO_AW:0] remaining;
  logic [7:0]       tx_dout;
  logic             tx_empty, tx_pop, rx_full, xfer_done;
  // the TX head is popped on the same edge that registers it onto the serializer bus
  assign tx_pop    = (state == IDLE && Go_i && !tx_empty) || (state == GAP && remaining != '0);
  assign xfer_done = state == XFER && spi.trnfer_cmplte_i;
  spi_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) u_tx (
    .clk(CLK_i), .rst_n(RSTn_i), .clr(RST_SYNC_i), .push(TX_Push_i), .din(TX_Data_i),
    .pop(tx_pop), .dout(tx_dout), .full(TX_Full_o), .empty(tx_empty), .level(TX_Level_o)
  );
  spi_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) u_rx (
    .clk(CLK_i), .rst_n(RSTn_i), .clr(RST_SYNC_i), .push(xfer_done), .din(spi.SPI_Read_Data_i),
    .pop(RX_Pop_i), .dout(RX_Data_o), .full(rx_full), .empty(RX_Empty_o), .level(RX_Level_o)
  );
  always_ff @(posedge CLK_i or negedge RSTn_i)
    if (!RSTn_i) begin
      state <= IDLE;
      remaining <= '0;
      {Busy_o, Done_o, Overrun_o} <= '0;
      {spi.start_o, spi.stop_o, spi.write_o, spi.read_o} <= '0;
      spi.SPI_Write_Data_o <= '0;
      spi.SPI_CS_Reg_o <= CS_IDLE;
    end else if (RST_SYNC_i) begin
      state <= IDLE;
      remaining <= '0;
      {Busy_o, Done_o, Overrun_o} <= '0;
      {spi.start_o, spi.stop_o, spi.write_o, spi.read_o} <= '0;
      spi.SPI_Write_Data_o <= '0;
      spi.SPI_CS_Reg_o <= CS_IDLE;
    end else begin
      Overrun_o <= (xfer_done && rx_full) || (Overrun_o && !Ovr_Clr_i);
      case (state)
        IDLE: if (Go_i) begin
          Busy_o <= 1'b1;
          if (tx_empty) begin
            state  <= DONE;
            Done_o <= 1'b1;
          end else begin
            state <= ISSUE;
            remaining <= TX_Level_o;
            {spi.start_o, spi.write_o, spi.read_o} <= 3'b111;
            spi.stop_o <= TX_Level_o == (FIFO_AW+1)'(1);
            spi.SPI_Write_Data_o <= tx_dout;
            spi.SPI_CS_Reg_o <= cs_decode(CS_Sel_i);
          end
        end
        ISSUE: state <= XFER;
        XFER: if (spi.trnfer_cmplte_i) begin
          state <= GAP;
          remaining <= remaining - (FIFO_AW+1)'(1);
          {spi.start_o, spi.stop_o, spi.write_o, spi.read_o} <= '0;
        end
        GAP: if (remaining != '0) begin
          state <= ISSUE;
          {spi.write_o, spi.read_o} <= 2'b11;
          spi.stop_o <= remaining == (FIFO_AW+1)'(1);
          spi.SPI_Write_Data_o <= tx_dout;
        end else begin
          state <= DONE;
          Done_o <= 1'b1;
          spi.SPI_CS_Reg_o <= CS_IDLE;
        end
        DONE: begin
          state  <= IDLE;
          Done_o <= 1'b0;
          Busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_burst_engine.sv
// tb_spi_burst_engine: directed bursts with a scoreboard checking every serializer command
module tb_spi_burst_engine;
  logic       CLK_i = 1'b0, RSTn_i = 1'b0, RST_SYNC_i = 1'b0;
  logic       TX_Push_i = 1'b0, RX_Pop_i = 1'b0, Go_i = 1'b0, Ovr_Clr_i = 1'b0;
  logic [7:0] TX_Data_i = 8'h00;
  logic [2:0] CS_Sel_i = 3'd0;
  logic       TX_Full_o, RX_Empty_o, Busy_o, Done_o, Overrun_o;
  logic [2:0] TX_Level_o, RX_Level_o;
  logic [7:0] RX_Data_o;
  spi_burst_engine_if sif();
  spi_burst_engine #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .CLK_i(CLK_i), .RSTn_i(RSTn_i), .RST_SYNC_i(RST_SYNC_i),
    .TX_Push_i(TX_Push_i), .TX_Data_i(TX_Data_i), .TX_Full_o(TX_Full_o), .TX_Level_o(TX_Level_o),
    .RX_Pop_i(RX_Pop_i), .RX_Data_o(RX_Data_o), .RX_Empty_o(RX_Empty_o), .RX_Level_o(RX_Level_o),
    .Go_i(Go_i), .CS_Sel_i(CS_Sel_i), .Busy_o(Busy_o), .Done_o(Done_o),
    .Overrun_o(Overrun_o), .Ovr_Clr_i(Ovr_Clr_i), .spi(sif)
  );
  always #5 CLK_i = ~CLK_i;
  typedef struct packed {logic s; logic p; logic [7:0] d; logic [7:0] cs;} exp_t;
  exp_t expq[$];
  exp_t e;
  int   checks = 0, errors = 0, issues = 0, dones = 0, iss0, d0;
  logic wr_prev = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge CLK_i) begin
    if (Done_o) dones++;
    if (sif.write_o && !wr_prev) begin
      issues++;
      if (expq.size() == 0) chk("unexpected_issue", 32'(expq.size()), 32'd1);
      else begin
        e = expq.pop_front();
        chk("issue_cmd", {sif.start_o, sif.stop_o, sif.read_o, sif.SPI_Write_Data_o, sif.SPI_CS_Reg_o},
            {e.s, e.p, 1'b1, e.d, e.cs});
      end
    end
    wr_prev = sif.write_o;
  end
  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask
  task automatic expect_cmd(input logic s, input logic p, input logic [7:0] d, input logic [7:0] cs);
    exp_t x;
    x = '{s: s, p: p, d: d, cs: cs};
    expq.push_back(x);
  endtask
  task automatic push(input logic [7:0] b);
    TX_Data_i = b;
    TX_Push_i = 1'b1;
    tick();
    TX_Push_i = 1'b0;
  endtask
  task automatic go(input logic [2:0] c);
    CS_Sel_i = c;
    Go_i = 1'b1;
    tick();
    Go_i = 1'b0;
  endtask
  task automatic complete(input logic [7:0] r);
    tick();
    sif.SPI_Read_Data_i = r;
    sif.trnfer_cmplte_i = 1'b1;
    tick();
    sif.trnfer_cmplte_i = 1'b0;
  endtask
  task automatic pop_rx(input string n, input logic [7:0] exp);
    chk(n, {RX_Empty_o, RX_Data_o}, {1'b0, exp});
    RX_Pop_i = 1'b1;
    tick();
    RX_Pop_i = 1'b0;
  endtask
  task automatic idle_chk(input string n);
    chk(n, {sif.start_o, sif.stop_o, sif.write_o, sif.read_o, sif.SPI_CS_Reg_o, sif.SPI_Write_Data_o,
            TX_Full_o, TX_Level_o, RX_Level_o, RX_Empty_o, Busy_o, Done_o, Overrun_o},
        {4'b0000, 8'hFF, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask
  initial begin
    sif.SPI_Read_Data_i = 8'h00;
    sif.trnfer_cmplte_i = 1'b0;
    tick();
    tick();
    idle_chk("reset_held");
    RSTn_i = 1'b1;
    tick();
    idle_chk("after_reset");
    // single-byte burst
    push(8'hA5);
    chk("t1_tx_level", 32'(TX_Level_o), 32'd1);
    expect_cmd(1'b1, 1'b1, 8'hA5, 8'hF7);
    go(3'd3);
    chk("t1_cycle1", {sif.start_o, sif.stop_o, sif.write_o, sif.read_o, sif.SPI_Write_Data_o, sif.SPI_CS_Reg_o},
        {4'hF, 8'hA5, 8'hF7});
    chk("t1_busy_pop", {Busy_o, TX_Level_o}, {1'b1, 3'd0});
    complete(8'h3C);
    chk("t1_gap_strobes", {sif.start_o, sif.stop_o, sif.write_o, sif.read_o}, 4'b0000);
    chk("t1_rx", {RX_Empty_o, RX_Data_o}, {1'b0, 8'h3C});
    tick();
    chk("t1_done", {Done_o, sif.SPI_CS_Reg_o}, {1'b1, 8'hFF});
    tick();
    chk("t1_end", {Done_o, Busy_o}, 2'b00);
    pop_rx("t1_pop", 8'h3C);
    chk("t1_rx_empty", RX_Empty_o, 1'b1);
    // three-byte burst
    push(8'h01); push(8'h02); push(8'h03);
    expect_cmd(1'b1, 1'b0, 8'h01, 8'hFE);
    expect_cmd(1'b0, 1'b0, 8'h02, 8'hFE);
    expect_cmd(1'b0, 1'b1, 8'h03, 8'hFE);
    go(3'd0);
    complete(8'h11);
    chk("t2_gap1", {sif.write_o, sif.read_o, sif.SPI_CS_Reg_o}, {2'b00, 8'hFE});
    tick();
    chk("t2_byte2", {sif.start_o, sif.stop_o, sif.write_o}, 3'b001);
    complete(8'h22);
    tick();
    complete(8'h33);
    chk("t2_rx_level", 32'(RX_Level_o), 32'd3);
    tick();
    chk("t2_done", Done_o, 1'b1);
    tick();
    pop_rx("t2_pop1", 8'h11);
    pop_rx("t2_pop2", 8'h22);
    pop_rx("t2_pop3", 8'h33);
    // go with TX empty
    iss0 = issues;
    go(3'd5);
    chk("t3_done", {Done_o, Busy_o, sif.SPI_CS_Reg_o}, {2'b11, 8'hFF});
    tick();
    chk("t3_end", {Done_o, Busy_o}, 2'b00);
    tick();
    chk("t3_no_strobe", issues, iss0);
    // fill RX to depth and check TX full
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    push(8'h50);
    chk("t4_tx_full", {TX_Full_o, TX_Level_o}, {1'b1, 3'd4});
    expect_cmd(1'b1, 1'b0, 8'h10, 8'h7F);
    expect_cmd(1'b0, 1'b0, 8'h20, 8'h7F);
    expect_cmd(1'b0, 1'b0, 8'h30, 8'h7F);
    expect_cmd(1'b0, 1'b1, 8'h40, 8'h7F);
    go(3'd7);
    complete(8'hA1); tick();
    complete(8'hA2); tick();
    complete(8'hA3); tick();
    complete(8'hA4);
    chk("t4_rx_fill", {RX_Level_o, Overrun_o}, {3'd4, 1'b0});
    tick(); tick();
    chk("t4_tx_drained", 32'(TX_Level_o), 32'd0);
    push(8'h50); push(8'h60);
    expect_cmd(1'b1, 1'b0, 8'h50, 8'hFD);
    expect_cmd(1'b0, 1'b1, 8'h60, 8'hFD);
    go(3'd1);
    complete(8'hB1);
    chk("t4_overrun", {Overrun_o, RX_Level_o, RX_Data_o}, {1'b1, 3'd4, 8'hA1});
    tick();
    complete(8'hB2);
    tick(); tick();
    chk("t4_sticky", {Overrun_o, RX_Level_o}, {1'b1, 3'd4});
    Ovr_Clr_i = 1'b1;
    tick();
    Ovr_Clr_i = 1'b0;
    chk("t4_ovr_clr", Overrun_o, 1'b0);
    pop_rx("t4_pop1", 8'hA1);
    pop_rx("t4_pop2", 8'hA2);
    pop_rx("t4_pop3", 8'hA3);
    pop_rx("t4_pop4", 8'hA4);
    // push during a burst is not sent
    push(8'h70); push(8'h71);
    expect_cmd(1'b1, 1'b0, 8'h70, 8'hFB);
    expect_cmd(1'b0, 1'b1, 8'h71, 8'hFB);
    iss0 = issues;
    go(3'd2);
    push(8'h72);
    complete(8'hC1); tick();
    complete(8'hC2); tick();
    chk("t5_done", Done_o, 1'b1);
    tick();
    chk("t5_tx_left", {TX_Level_o, Busy_o}, {3'd1, 1'b0});
    chk("t5_two_xfers", issues - iss0, 2);
    // synchronous clear mid-XFER
    expect_cmd(1'b1, 1'b1, 8'h72, 8'hFE);
    go(3'd0);
    tick();
    d0 = dones;
    RST_SYNC_i = 1'b1;
    tick();
    RST_SYNC_i = 1'b0;
    idle_chk("sync_rst");
    tick(); tick();
    chk("sync_rst_no_done", dones, d0);
    push(8'h5A);
    expect_cmd(1'b1, 1'b1, 8'h5A, 8'hFE);
    go(3'd0);
    complete(8'h77);
    chk("t6_rx", {RX_Empty_o, RX_Data_o}, {1'b0, 8'h77});
    tick();
    chk("t6_done", Done_o, 1'b1);
    tick();
    // asynchronous reset mid-XFER
    push(8'h66);
    expect_cmd(1'b1, 1'b1, 8'h66, 8'hFE);
    go(3'd0);
    tick();
    d0 = dones;
    RSTn_i = 1'b0;
    #1;
    idle_chk("async_rst");
    tick();
    RSTn_i = 1'b1;
    tick();
    idle_chk("after_async_rst");
    chk("async_rst_no_done", dones, d0);
    push(8'h99);
    expect_cmd(1'b1, 1'b1, 8'h99, 8'hEF);
    go(3'd4);
    complete(8'h55);
    tick();
    chk("t7_done", {Done_o, sif.SPI_CS_Reg_o}, {1'b1, 8'hFF});
    tick();
    pop_rx("t7_pop", 8'h55);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_burst_engine.md
# spi_burst_engine

Byte-burst sequencer that sits directly upstream of `serializer_deserializer` in the SPI master fabric design, on the bus-clock domain. It buffers host-written bytes in a TX FIFO and drives the serializer's command handshake one byte at a time. Each received byte is captured into an RX FIFO, so software can issue multi-byte transactions without polling after every byte.

## Interface
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, 4 to 256.
- `FIFO_AW`, 4: log2(`FIFO_DEPTH`); level ports are `FIFO_AW+1` bits wide.

- `CLK_i` in 1: bus clock; all logic is on its rising edge.
- `RSTn_i` in 1: asynchronous, active-low reset.
- `RST_SYNC_i` in 1: synchronous clear, active-high. It is driven from the fabric bus reset.
- `TX_Push_i` in 1: write `TX_Data_i` into the TX FIFO.
- `TX_Data_i` in 8: byte to transmit.
- `TX_Full_o` out 1: TX FIFO is full.
- `TX_Level_o` out `FIFO_AW+1`: TX occupancy.
- `RX_Pop_i` in 1: discard the head of the RX FIFO.
- `RX_Data_o` out 8: RX head, first-word-fall-through.
- `RX_Empty_o` out 1: RX FIFO is empty.
- `RX_Level_o` out `FIFO_AW+1`: RX occupancy.
- `Go_i` in 1: single-cycle pulse that starts a burst.
- `CS_Sel_i` in 3: slave-select index, sampled on `Go_i`.
- `Busy_o` out 1: a burst is in progress.
- `Done_o` out 1: single-cycle pulse at the end of a burst.
- `Overrun_o` out 1: sticky flag; an RX byte was dropped.
- `Ovr_Clr_i` in 1: clears `Overrun_o`.
- `start_o`, `stop_o`, `write_o`, `read_o` out 1 each: serializer command strobes.
- `SPI_Write_Data_o` out 8: byte presented to the serializer.
- `SPI_Read_Data_i` in 8: byte returned by the serializer.
- `trnfer_cmplte_i` in 1: single-cycle byte-complete pulse from the serializer.
- `SPI_CS_Reg_o` out 8: active-low chip-select vector.

## Operation
- **States:** IDLE, ISSUE, XFER, GAP, DONE.
- **IDLE:**
  - On `Go_i`, snapshot `TX_Level_o` into `remaining` and latch `CS_Sel_i`.
  - If the snapshot is 0, go to DONE with no transfer.
  - Otherwise set `first=1` and go to ISSUE.
  - `Go_i` is ignored in every other state.
- **ISSUE:**
  - Pop the TX head into `SPI_Write_Data_o`.
  - Assert `write_o` and `read_o` (full duplex).
  - Assert `start_o` if `first`; assert `stop_o` if `remaining==1`.
  - Drive `SPI_CS_Reg_o` to `~(8'b1 << cs)`.
  - Go to XFER.
- **XFER:**
  - Hold every command strobe and `SPI_Write_Data_o` stable until `trnfer_cmplte_i`.
  - On `trnfer_cmplte_i`:
    - Push `SPI_Read_Data_i` into RX if RX is not full. If RX is full, drop the byte and set `Overrun_o`.
    - Decrement `remaining` and clear `first`.
    - Go to GAP.
- **GAP:** All strobes are low. Go to ISSUE if `remaining!=0`, otherwise go to DONE.
- **DONE:** Pulse `Done_o`, deassert CS (`8'hFF`), go to IDLE.
- **Host pushes during a burst** are accepted but not sent in that burst; the snapshot bounds the burst.
- **FIFO boundaries:**
  - A push while full is ignored and the level is unchanged.
  - A pop while empty is ignored.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Overrun flag:** if `Ovr_Clr_i` and a new overrun occur in the same cycle, the set wins.
- **`RST_SYNC_i`** (including mid-burst): at the next edge, return to IDLE, flush both FIFOs, clear `Overrun_o`, drop all strobes and set CS to `8'hFF`. No `Done_o` is produced.
- **`RSTn_i`** (and `RST_SYNC_i`) reset values:
  - `SPI_CS_Reg_o=8'hFF`.
  - `SPI_Write_Data_o=0`.
  - `TX_Level_o=0` and `RX_Level_o=0`.
  - `RX_Empty_o=1`.
  - Every other output is 0.

## Timing
- All outputs are registered; `RX_Data_o` comes directly from the RX storage read at the head pointer.
- `Go_i` in cycle 0 gives strobes high and CS low in cycle 1.
- `trnfer_cmplte_i` in cycle N:
  - Strobes low in N+1.
  - RX byte visible with `RX_Empty_o=0` in N+1.
  - Next byte's strobes high in N+2.
- The last byte's completion in cycle N gives `Done_o` high and CS `8'hFF` in N+2; `Busy_o` falls in N+3.
- `Busy_o` is 1 in ISSUE, XFER, GAP and DONE.
- `Go_i` with TX empty gives `Done_o` in cycle 1.

## Structure
- `spi_burst_defs.vh` holds:
  - state localparams: IDLE=0, ISSUE=1, XFER=2, GAP=3, DONE=4;
  - `CS_IDLE=8'hFF`.
- Sub-module `spi_byte_fifo` (parameters `FIFO_DEPTH`, `FIFO_AW`), instantiated twice for TX and RX:
  - synchronous FWFT FIFO with level, full and empty;
  - same `RSTn_i` and `RST_SYNC_i` as this block.
- The top level holds the FSM, the `remaining` counter, the CS decode and the overrun flag.

## Test plan
- **Single-byte burst:** push 8'hA5, `CS_Sel_i`=3, pulse `Go_i`.
  - Cycle 1: `start_o=stop_o=write_o=read_o=1`, `SPI_Write_Data_o=8'hA5`, CS=8'hF7.
  - Complete with read 8'h3C: `RX_Data_o=8'h3C`, `Done_o` one cycle, CS=8'hFF.
- **Three-byte burst** of 01, 02, 03:
  - `start_o` on byte 1 only, `stop_o` on byte 3 only.
  - One low-strobe GAP cycle between bytes; RX level reaches 3.
- **Go with TX empty:** `Done_o` in cycle 1; no strobe ever asserts.
- **RX overrun with `FIFO_DEPTH`=4:** pre-fill RX to 4, run a 2-byte burst.
  - `Overrun_o=1`, RX contents unchanged.
  - `Ovr_Clr_i` clears the flag.
- **Push during a burst:** push 2 bytes and Go, push 1 more mid-burst.
  - Exactly 2 transfers; `TX_Level_o=1` after `Done_o`.
  - Also check that a push on a full TX FIFO is ignored.
- **Reset mid-XFER:** first `RST_SYNC_i`, then `RSTn_i`.
  - Each time: strobes 0, CS=8'hFF, both levels 0, no `Done_o`, `Busy_o=0`.
  - A following Go works normally.
